// File: rtl/mips_bus_arbiter.sv
// Multi-channel memory bus arbiter: grants one requester at a time, forwards it to a stallable bus.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default build uses fixed priority.
module mips_bus_arbiter #(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_CH-1:0]        ch_read,
    input  logic [N_CH-1:0]        ch_write,
    input  logic [N_CH*AW-1:0]     ch_address,
    input  logic [N_CH*DW-1:0]     ch_writedata,
    input  logic [N_CH*DW/8-1:0]   ch_byteenable,
    output logic [N_CH-1:0]        ch_ready,
    output logic                   ch_error,
    output logic [DW-1:0]          ch_readdata,
    output logic [AW-1:0]          address,
    output logic                   read,
    output logic                   write,
    output logic [DW-1:0]          writedata,
    output logic [DW/8-1:0]        byteenable,
    input  logic                   waitrequest,
    input  logic [DW-1:0]          readdata,
    output logic                   busy
);

    localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned BW = DW / 8;
    localparam logic [15:0] ToLast = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   grant_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [BW-1:0]   be_q;
    logic            wr_q;
    logic [15:0]     cnt_q;
    logic            err_q;
    logic [DW-1:0]   rdata_q;

    logic [N_CH-1:0] cand;
    logic            any_cand;
    logic [IW-1:0]   win;
    logic [N_CH-1:0] cand_sh;
    logic [AW-1:0]   addr_sel;
    logic [DW-1:0]   wdata_sel;
    logic [BW-1:0]   be_sel;
    logic            wr_sel;
    logic            grant_en;
    logic            timeout_hit;

    assign cand     = ch_read | ch_write;
    assign any_cand = |cand;
    assign grant_en = (state_q == StIdle) && any_cand;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0] ptr_q;
    int unsigned   idx;
    logic          found;

    // Scan starts just after the last-granted channel and wraps.
    always_comb begin
        win     = '0;
        found   = 1'b0;
        idx     = 0;
        cand_sh = '0;
        for (int unsigned off = 1; off <= N_CH; off++) begin
            idx     = (int'(ptr_q) + off) % N_CH;
            cand_sh = cand >> idx;
            if (!found && cand_sh[0]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= IW'(N_CH - 1);
        end else if (grant_en) begin
            ptr_q <= win;
        end
    end
`else
    always_comb begin
        win     = '0;
        cand_sh = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            cand_sh = cand >> i;
            if (cand_sh[0]) begin
                win = IW'(i);
            end
        end
    end
`endif

    assign addr_sel  = AW'(ch_address >> (int'(win) * AW));
    assign wdata_sel = DW'(ch_writedata >> (int'(win) * DW));
    assign be_sel    = BW'(ch_byteenable >> (int'(win) * BW));
    // A simultaneous read+write on one channel is performed as the write.
    assign wr_sel    = |(ch_write & (N_CH'(1) << win));

    assign timeout_hit = (state_q == StIssue) && waitrequest && (cnt_q == ToLast);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_cand) state_d = StIssue;
            StIssue: if (!waitrequest || timeout_hit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else if (grant_en) begin
            grant_q <= win;
            addr_q  <= addr_sel;
            wdata_q <= wdata_sel;
            be_q    <= be_sel;
            wr_q    <= wr_sel;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else if (state_q == StIssue) begin
            if (timeout_hit) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end else if (waitrequest) begin
                cnt_q <= cnt_q + 16'd1;
            end else if (!wr_q) begin
                rdata_q <= readdata;
            end
        end
    end

    always_comb begin
        address     = addr_q;
        writedata   = wdata_q;
        byteenable  = be_q;
        ch_readdata = rdata_q;
        read        = (state_q == StIssue) && !wr_q;
        write       = (state_q == StIssue) && wr_q;
        busy        = (state_q != StIdle);
        ch_ready    = (state_q == StDone) ? (N_CH'(1) << grant_q) : '0;
        ch_error    = (state_q == StDone) && err_q;
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: scoreboard of expected completions per scenario.
// Memory model returns address ^ 32'hDEADBEFF as read data.
module tb_mips_bus_arbiter;

    localparam logic [31:0] K = 32'hDEADBEFF;

    logic        clk;
    logic        reset;
    logic [1:0]  ch_read;
    logic [1:0]  ch_write;
    logic [63:0] ch_address;
    logic [63:0] ch_writedata;
    logic [7:0]  ch_byteenable;
    logic [1:0]  ch_ready;
    logic        ch_error;
    logic [31:0] ch_readdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        busy;

    typedef struct {
        int          ch;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    assign readdata = address ^ K;

    mips_bus_arbiter #(
        .N_CH    (2),
        .AW      (32),
        .DW      (32),
        .TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ch_read       (ch_read),
        .ch_write      (ch_write),
        .ch_address    (ch_address),
        .ch_writedata  (ch_writedata),
        .ch_byteenable (ch_byteenable),
        .ch_ready      (ch_ready),
        .ch_error      (ch_error),
        .ch_readdata   (ch_readdata),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cycles, output bit expired);
        cycles  = 0;
        expired = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            cycles++;
            if (ch_ready != 2'b00) begin
                expired = 1'b0;
                break;
            end
        end
    endtask

    task automatic pop_expected(output exp_t e, output bit empty);
        empty = (sb.size() == 0);
        if (!empty) e = sb.pop_front();
        else e = '{-1, 32'h0, 1'b0};
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        ch_read       = '0;
        ch_write      = '0;
        ch_address    = '0;
        ch_writedata  = '0;
        ch_byteenable = '0;
        waitrequest   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({read, write, busy, ch_error, ch_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000", {read, write, busy, ch_error, ch_ready});
        end
        n_checks++;
        if ({address, writedata, byteenable, ch_readdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got addr %h wd %h be %h rd %h want all 0",
                     address, writedata, byteenable, ch_readdata);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_read();
        int   cyc;
        bit   exp_d, empty;
        exp_t e;
        ch_address[31:0] = 32'h10;
        ch_read          = 2'b01;
        waitrequest      = 1'b0;
        sb.push_back('{0, 32'hDEADBEEF, 1'b0});
        tick();
        n_checks++;
        if (!(read === 1'b1 && write === 1'b0 && address === 32'h10)) begin
            n_fail++;
            $display("FAIL read_strobe: got rd %b wr %b addr %h want 1 0 00000010", read, write, address);
        end
        wait_ready(cyc, exp_d);
        pop_expected(e, empty);
        n_checks++;
        if (exp_d || empty || (cyc + 1) != 2) begin
            n_fail++;
            $display("FAIL read_latency: got %0d edges (expired %0d) want 2", cyc + 1, exp_d);
        end
        n_checks++;
        if (ch_ready !== (2'b01 << e.ch) || ch_readdata !== e.rdata || ch_error !== e.err) begin
            n_fail++;
            $display("FAIL read_result: got rdy %b rd %h err %b want %b %h %b",
                     ch_ready, ch_readdata, ch_error, 2'b01 << e.ch, e.rdata, e.err);
        end
        ch_read = 2'b00;
        tick();
        n_checks++;
        if (ch_ready !== 2'b00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL read_pulse_len: got rdy %b busy %b want 00 0", ch_ready, busy);
        end
    endtask

    task automatic test_write_stall();
        int   strobes = 0, rises = 0, unstable = 0;
        bit   prev_w = 1'b0, got = 1'b0, empty;
        exp_t e;
        ch_address[31:0]    = 32'h20;
        ch_writedata[31:0]  = 32'h12345678;
        ch_byteenable[3:0]  = 4'hF;
        ch_write            = 2'b01;
        waitrequest         = 1'b1;
        sb.push_back('{0, 32'hDEADBEEF, 1'b0});
        for (int i = 0; i < 20; i++) begin
            tick();
            if (write && !prev_w) rises++;
            prev_w = write;
            if (write) begin
                strobes++;
                if (address !== 32'h20 || writedata !== 32'h12345678 || byteenable !== 4'hF ||
                    read !== 1'b0) unstable++;
                if (strobes == 4) waitrequest = 1'b0;
            end
            if (ch_ready != 2'b00) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got || strobes != 4 || rises != 1 || unstable != 0) begin
            n_fail++;
            $display("FAIL write_stall_bus: got ready %0d strobes %0d rises %0d unstable %0d want 1 4 1 0",
                     got, strobes, rises, unstable);
        end
        pop_expected(e, empty);
        n_checks++;
        if (empty || ch_ready !== (2'b01 << e.ch) || ch_readdata !== e.rdata || ch_error !== e.err) begin
            n_fail++;
            $display("FAIL write_result: got rdy %b rd %h err %b want %b %h %b",
                     ch_ready, ch_readdata, ch_error, 2'b01 << e.ch, e.rdata, e.err);
        end
        ch_write = 2'b00;
        tick();
    endtask

    task automatic test_drop_after_grant();
        int   cyc;
        bit   exp_d, empty;
        exp_t e;
        ch_address[63:32] = 32'h40;
        ch_read           = 2'b10;
        waitrequest       = 1'b1;
        sb.push_back('{1, 32'h40 ^ K, 1'b0});
        tick();
        ch_read = 2'b00;
        tick();
        tick();
        waitrequest = 1'b0;
        wait_ready(cyc, exp_d);
        pop_expected(e, empty);
        n_checks++;
        if (exp_d || empty || ch_ready !== (2'b01 << e.ch) || ch_readdata !== e.rdata ||
            ch_error !== e.err) begin
            n_fail++;
            $display("FAIL drop_after_grant: got rdy %b rd %h err %b expired %0d want %b %h %b",
                     ch_ready, ch_readdata, ch_error, exp_d, 2'b01 << e.ch, e.rdata, e.err);
        end
        tick();
    endtask

    task automatic test_priority();
        int   served = 0;
        bit   empty;
        exp_t e;
        ch_address  = {32'h200, 32'h100};
        ch_read     = 2'b11;
        waitrequest = 1'b0;
        sb.push_back('{0, 32'h100 ^ K, 1'b0});
        sb.push_back('{1, 32'h200 ^ K, 1'b0});
        for (int i = 0; i < 40 && served < 2; i++) begin
            tick();
            if (ch_ready != 2'b00) begin
                pop_expected(e, empty);
                served++;
                n_checks++;
                if (empty || ch_ready !== (2'b01 << e.ch) || ch_readdata !== e.rdata ||
                    ch_error !== e.err) begin
                    n_fail++;
                    $display("FAIL priority_order_%0d: got rdy %b rd %h err %b want %b %h %b",
                             served, ch_ready, ch_readdata, ch_error, 2'b01 << e.ch, e.rdata, e.err);
                end
                ch_read = ch_read & ~ch_ready;
            end
        end
        n_checks++;
        if (served != 2) begin
            n_fail++;
            $display("FAIL priority_count: got %0d completions want 2", served);
        end
        tick();
    endtask

    task automatic test_timeout();
        int   strobes = 0;
        bit   got = 1'b0, empty;
        exp_t e;
        ch_address[31:0] = 32'h30;
        ch_read          = 2'b01;
        waitrequest      = 1'b1;
        sb.push_back('{0, 32'h0, 1'b1});
        for (int i = 0; i < 20; i++) begin
            tick();
            if (read) strobes++;
            if (ch_ready != 2'b00) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got || strobes != 4) begin
            n_fail++;
            $display("FAIL timeout_strobes: got ready %0d strobes %0d want 1 4", got, strobes);
        end
        pop_expected(e, empty);
        n_checks++;
        if (empty || ch_ready !== (2'b01 << e.ch) || ch_readdata !== e.rdata || ch_error !== e.err ||
            read !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_result: got rdy %b rd %h err %b strobe %b want %b %h %b 0",
                     ch_ready, ch_readdata, ch_error, read, 2'b01 << e.ch, e.rdata, e.err);
        end
        ch_read = 2'b00;
        tick();
        waitrequest = 1'b0;
        n_checks++;
        if (ch_error !== 1'b0 || ch_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_clear: got err %b rdy %b want 0 00", ch_error, ch_ready);
        end
    endtask

    task automatic test_reset_mid_issue();
        int   stray = 0, cyc;
        bit   exp_d, empty;
        exp_t e;
        ch_address[63:32]   = 32'h50;
        ch_writedata[63:32] = 32'hCAFEF00D;
        ch_byteenable[7:4]  = 4'h3;
        ch_write            = 2'b10;
        waitrequest         = 1'b1;
        tick();
        tick();
        n_checks++;
        if (write !== 1'b1 || busy !== 1'b1 || writedata !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL mid_issue_pre: got wr %b busy %b wd %h want 1 1 cafef00d",
                     write, busy, writedata);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (read !== 1'b0 || write !== 1'b0 || busy !== 1'b0 || ch_readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: got rd %b wr %b busy %b rdata %h want 0 0 0 0",
                     read, write, busy, ch_readdata);
        end
        ch_write = 2'b00;
        #2 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ch_ready != 2'b00) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL aborted_no_ready: got %0d ready cycles want 0", stray);
        end
        waitrequest      = 1'b0;
        ch_address[31:0] = 32'h10;
        ch_read          = 2'b01;
        sb.push_back('{0, 32'hDEADBEEF, 1'b0});
        wait_ready(cyc, exp_d);
        pop_expected(e, empty);
        n_checks++;
        if (exp_d || empty || cyc != 2 || ch_ready !== (2'b01 << e.ch) ||
            ch_readdata !== e.rdata || ch_error !== e.err) begin
            n_fail++;
            $display("FAIL post_reset_read: got edges %0d rdy %b rd %h err %b want 2 %b %h %b",
                     cyc, ch_ready, ch_readdata, ch_error, 2'b01 << e.ch, e.rdata, e.err);
        end
        ch_read = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_stall();
        test_drop_after_grant();
        test_priority();
        test_timeout();
        test_reset_mid_issue();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover entries want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
